// File: rtl/riscv_lsu_pkg.sv
// Shared load/store-unit definitions: funct3 access codes, FSM states and
// legality helpers used by the memory-stage LSU.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } lsu_state_t;

  // Stores only exist in signed-size form; BU/HU are load-only encodings.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return !lo[0];
      F3_W:        return lo == 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte/half lane of a memory word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    data = {{16{half_lane[15]}}, half_lane};
      F3_W:    data = rdata;
      F3_BU:   data = {24'd0, byte_lane};
      F3_HU:   data = {16'd0, half_lane};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one req/ack data-memory transaction per
// load/store, stalls the pipeline while it is outstanding, and aligns load data.
module mem_stage_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] writeDataM,
  output logic [31:0] readDataM,
  output logic        stallM,
  output logic        misalignM,
  output logic        busErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_t    state, state_next;
  logic [CW-1:0] cnt;
  logic          access, access_ok, start;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [2:0]    lat_f3;
  logic [1:0]    lat_lo;
  logic [31:0]   load_data;

  // A simultaneous read+write is handled as a store.
  assign access    = memReadM | memWriteM;
  assign access_ok = f3_legal(memWriteM, funct3M) && addr_aligned(funct3M, ALUResultM[1:0]);

  always_comb begin
    case (funct3M)
      F3_B, F3_BU: begin
        be_next    = 4'b0001 << ALUResultM[1:0];
        wdata_next = {4{writeDataM[7:0]}};
      end
      F3_H, F3_HU: begin
        be_next    = 4'b0011 << {ALUResultM[1], 1'b0};
        wdata_next = {2{writeDataM[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = writeDataM;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    stallM     = 1'b0;
    misalignM  = 1'b0;
    start      = 1'b0;
    case (state)
      S_IDLE: begin
        if (access) begin
          if (access_ok) begin
            stallM     = 1'b1;
            start      = 1'b1;
            state_next = S_BUSY;
          end else begin
            misalignM  = 1'b1;
          end
        end
      end
      S_BUSY: begin
        stallM = 1'b1;
        if (dmem_ack || cnt == CNT_LAST) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  lsu_load_align u_align (
    .funct3  (lat_f3),
    .addr_lo (lat_lo),
    .rdata   (dmem_rdata),
    .data    (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      readDataM  <= '0;
      busErrM    <= 1'b0;
      lat_f3     <= '0;
      lat_lo     <= '0;
    end else begin
      busErrM <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= memWriteM;
            dmem_addr  <= {ALUResultM[31:2], 2'b00};
            dmem_be    <= be_next;
            dmem_wdata <= memWriteM ? wdata_next : '0;
            lat_f3     <= funct3M;
            lat_lo     <= ALUResultM[1:0];
            cnt        <= '0;
          end
        end
        S_BUSY: begin
          // Ack wins over a timeout landing in the same cycle.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) readDataM <= load_data;
          end else if (cnt == CNT_LAST) begin
            dmem_req  <= 1'b0;
            busErrM   <= 1'b1;
            readDataM <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE:  cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed spot checks plus randomized
// loads/stores checked every cycle against a transaction-level model.
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        memReadM, memWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, writeDataM;
  logic [31:0] readDataM;
  logic        stallM, misalignM, busErrM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;

  mem_stage_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .memReadM(memReadM), .memWriteM(memWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .writeDataM(writeDataM),
    .readDataM(readDataM), .stallM(stallM), .misalignM(misalignM), .busErrM(busErrM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_mis, exp_berr, exp_req, exp_busy, exp_we;
  logic [31:0] exp_rd, exp_addr, exp_wd;
  logic [3:0]  exp_be;

  logic        trace [0:31];
  int          ntr;
  logic        saw_req, saw_mis, saw_berr;
  logic [31:0] last_rd, bus_addr, bus_wd;
  logic [3:0]  bus_be;
  logic        bus_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // Model rules: legality, byte enables, lane replication, load extension.
  function automatic logic m_ok(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int bytes;
    logic legal;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    bytes = 1 << f3[1:0];
    return legal && ((a % bytes) == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int bytes;
    bytes = 1 << f3[1:0];
    return 4'(((1 << bytes) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'd0) return {24'd0, d[7:0]} * 32'h01010101;
    if (f3[1:0] == 2'd1) return {16'd0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v, m;
    int bytes;
    bytes = 1 << f3[1:0];
    if (bytes == 4) return w;
    v = w >> (8 * a[1:0]);
    m = (bytes == 1) ? 32'h000000FF : 32'h0000FFFF;
    v = v & m;
    if (!f3[2] && v[8*bytes-1]) v = v | ~m;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stallM", {31'd0, stallM}, {31'd0, exp_stall});
      chk("misalignM", {31'd0, misalignM}, {31'd0, exp_mis});
      chk("busErrM", {31'd0, busErrM}, {31'd0, exp_berr});
      chk("dmem_req", {31'd0, dmem_req}, {31'd0, exp_req});
      chk("readDataM", readDataM, exp_rd);
      if (exp_busy) begin
        chk("dmem_we", {31'd0, dmem_we}, {31'd0, exp_we});
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_be", {28'd0, dmem_be}, {28'd0, exp_be});
        if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note(input bit first_busy);
    if (ntr < 32) trace[ntr] = stallM;
    ntr++;
    saw_req  |= dmem_req;
    saw_mis  |= misalignM;
    saw_berr |= busErrM;
    last_rd  = readDataM;
    if (first_busy) begin
      bus_we = dmem_we; bus_addr = dmem_addr; bus_be = dmem_be; bus_wd = dmem_wdata;
    end
  endtask

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0; exp_req = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic idle_cycle();
    memReadM = 1'b0; memWriteM = 1'b0;
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    set_idle_exp();
    @(negedge clk);
    tick();
    dmem_ack = 1'b0;
  endtask

  // ack_at < 0 or >= TIMEOUT means the memory never answers.
  task automatic do_txn(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rdat);
    logic st, timed;
    st = wr;
    timed = (ack_at < 0) || (ack_at >= TIMEOUT);
    memReadM = rd; memWriteM = wr; funct3M = f3; ALUResultM = a; writeDataM = wd;
    dmem_ack = 1'b0;
    ntr = 0; saw_req = 1'b0; saw_mis = 1'b0; saw_berr = 1'b0;
    set_idle_exp();
    if (!m_ok(st, f3, a)) begin
      exp_mis = 1'b1;
      @(negedge clk); note(1'b0); tick();
    end else begin
      exp_stall = 1'b1;
      @(negedge clk); note(1'b0); tick();
      exp_we = st; exp_addr = {a[31:2], 2'b00}; exp_be = m_be(f3, a); exp_wd = m_wd(f3, wd);
      for (int n = 0; n < TIMEOUT; n++) begin
        exp_stall = 1'b1; exp_req = 1'b1; exp_busy = 1'b1;
        if (n == ack_at) begin dmem_ack = 1'b1; dmem_rdata = rdat; end
        @(negedge clk); note(n == 0); tick();
        dmem_ack = 1'b0;
        if (n == ack_at) break;
      end
      set_idle_exp();
      if (timed) exp_rd = '0;
      else if (!st) exp_rd = m_ext(f3, a, rdat);
      exp_berr = timed;
      dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      @(negedge clk); note(1'b0); tick();
      dmem_ack = 1'b0;
    end
    memReadM = 1'b0; memWriteM = 1'b0;
    set_idle_exp();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  good_ld [5];
    logic [2:0]  f3;
    logic [31:0] a;
    logic        rd, wr;
    int          k, ack_at, bytes;
    good_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst = 1'b1; memReadM = 1'b0; memWriteM = 1'b0; funct3M = '0;
    ALUResultM = '0; writeDataM = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    exp_rd = '0; exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wd = '0;
    set_idle_exp();
    repeat (3) @(posedge clk);
    #2;
    chk("reset readDataM", readDataM, 32'h0);
    chk("reset stallM", {31'd0, stallM}, 32'd0);
    chk("reset dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("reset misalignM", {31'd0, misalignM}, 32'd0);
    chk("reset busErrM", {31'd0, busErrM}, 32'd0);
    chk("reset dmem_be", {28'd0, dmem_be}, 32'd0);
    chk("reset dmem_addr", dmem_addr, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    chk_en = 1'b1;
    idle_cycle();

    do_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    chk("LW ntr", ntr, 3);
    chk("LW stall trace", {29'd0, trace[0], trace[1], trace[2]}, 32'b110);
    chk("LW readDataM", last_rd, 32'hDEADBEEF);
    do_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80123456);
    chk("LB readDataM", last_rd, 32'hFFFFFF80);
    do_txn(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 2, 32'h80123456);
    chk("LBU readDataM", last_rd, 32'h00000080);
    do_txn(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'hBEEF1234);
    chk("LHU readDataM", last_rd, 32'h0000BEEF);
    do_txn(1'b0, 1'b1, 3'b000, 32'h201, 32'h12345678, 0, 32'h0);
    chk("SB be", {28'd0, bus_be}, 32'b0010);
    chk("SB wdata", bus_wd, 32'h78787878);
    chk("SB we", {31'd0, bus_we}, 32'd1);
    chk("SB addr", bus_addr, 32'h200);
    chk("SB keeps readDataM", last_rd, 32'h0000BEEF);
    do_txn(1'b0, 1'b1, 3'b001, 32'h202, 32'h12345678, 1, 32'h0);
    chk("SH be", {28'd0, bus_be}, 32'b1100);
    chk("SH wdata", bus_wd, 32'h56785678);
    do_txn(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
    chk("LW misalign pulse", {31'd0, saw_mis}, 32'd1);
    chk("LW misalign no req", {31'd0, saw_req}, 32'd0);
    do_txn(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h0);
    chk("LH misalign pulse", {31'd0, saw_mis}, 32'd1);
    chk("LH misalign no req", {31'd0, saw_req}, 32'd0);
    idle_cycle();
    do_txn(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, -1, 32'h0);
    chk("timeout busErr", {31'd0, saw_berr}, 32'd1);
    chk("timeout cycles", ntr, TIMEOUT + 2);
    chk("timeout readDataM", last_rd, 32'h0);

    // Reset while the request is outstanding.
    do_txn(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 0, 32'h11223344);
    chk_en = 1'b0;
    memReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h500;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("midrst readDataM", readDataM, 32'h0);
    memReadM = 1'b0;
    #1;
    chk("midrst idle stall", {31'd0, stallM}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_ack = 1'b0;
    chk("postrst ack req", {31'd0, dmem_req}, 32'd0);
    chk("postrst ack stall", {31'd0, stallM}, 32'd0);
    chk("postrst ack rd", readDataM, 32'h0);
    exp_rd = '0;
    set_idle_exp();
    chk_en = 1'b1;

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      rd = (k < 5) || (k == 9);
      wr = (k >= 5);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (wr) f3 = 3'($urandom_range(0, 2));
      else f3 = good_ld[$urandom_range(0, 4)];
      a = $urandom;
      bytes = 1 << f3[1:0];
      if ($urandom_range(0, 2) != 0) a = a & ~(32'(bytes) - 32'd1);
      k = $urandom_range(0, 19);
      if (k < 15) ack_at = $urandom_range(0, 4);
      else if (k < 18) ack_at = $urandom_range(5, 17);
      else ack_at = -1;
      do_txn(rd, wr, f3, a, $urandom, ack_at, $urandom);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
